// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int          FQ_DEPTH = 2;
  localparam int          CNT_W    = $clog2(FQ_DEPTH + 1);
  localparam logic [31:0] PC_STEP  = 32'd4;

  // One fetched instruction paired with its byte PC.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry fetch packet FIFO. The head lives in its own register so the
// outputs to decode come straight from flops and hold still under stall.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  fetch_pkt_t       push_pkt_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_pkt_t       head_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_pkt_t       head_q, head_d;
  fetch_pkt_t       tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state: flush wins; otherwise push/pop in any combination. A pop
  // with an empty queue cannot happen since pop is qualified by valid_o.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (count_q == '0) head_d = push_pkt_i;
          else               tail_d = push_pkt_i;
          count_d = count_q + CNT_W'(1);
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - CNT_W'(1);
        end
        2'b11: begin
          // Count unchanged; new packet lands behind whatever remains.
          if (count_q == CNT_W'(1)) begin
            head_d = push_pkt_i;
          end else begin
            head_d = tail_q;
            tail_d = push_pkt_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Queue storage and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

  // The issue throttle upstream must make these unreachable.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_i && !flush_i && count_q == CNT_W'(FQ_DEPTH)));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(pop_i && count_q == '0));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, addresses the icache every
// cycle, pairs each returned word with its PC and queues it for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [29:0] icache_addr,
  input  logic [31:0] icache_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             req_valid_q, req_valid_d;
  logic [CNT_W-1:0] count;
  logic             deq, issue, push;
  logic [2:0]       occ;
  logic [31:0]      issue_pc;
  fetch_pkt_t       push_pkt, head;

  assign deq      = out_valid & out_ready;
  assign issue_pc = redirect_valid ? {redirect_pc[31:2], 2'b00} : fetch_pc_q;
  assign icache_addr = issue_pc[31:2];

  // Occupancy after this edge if nothing new were issued; issuing only when
  // it is at most 1 leaves room for the response that lands next cycle.
  assign occ   = 3'(count) + 3'(req_valid_q) - 3'(deq);
  assign issue = redirect_valid | (occ <= 3'd1);

  // A response arriving during a redirect belongs to the dead path.
  assign push        = req_valid_q & ~redirect_valid;
  assign push_pkt.pc   = req_pc_q;
  assign push_pkt.inst = icache_inst;

  // PC and in-flight request bookkeeping.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = 1'b0;
    if (issue) begin
      req_pc_d    = issue_pc;
      req_valid_d = 1'b1;
      fetch_pc_d  = issue_pc + PC_STEP;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
    end
  end

  fetch_queue u_fq (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_pkt_i (push_pkt),
    .pop_i      (deq),
    .flush_i    (redirect_valid),
    .head_o     (head),
    .valid_o    (out_valid),
    .count_o    (count)
  );

  assign out_pc   = head.pc;
  assign out_inst = head.inst;

endmodule
